// File: rtl/banked_ram.sv
// banked_ram: single-port synchronous RAM built from NUM_BANKS identical banks.
// The upper ADDR bits pick the bank and the lower BANK_ADDR_W bits pick the word.
// After every reset the whole array is zero-filled, one word index per cycle
// across all banks in parallel, before requests are accepted.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST_N      in   synchronous active-low reset
//   REQ        in   access request, sampled on the rising edge
//   R_W        in   1 = read, 0 = write (qualified by REQ)
//   ADDR       in   {bank select, word index}
//   DATA_IN    in   write data
//   READY      out  high while requests are being accepted (RUN state)
//   DATA_OUT   out  read data from the last accepted read (registered)
//   DOUT_VALID out  one-cycle strobe marking new DATA_OUT
module banked_ram #(
  parameter int DATA_W      = 8,
  parameter int BANK_ADDR_W = 3,
  parameter int NUM_BANKS   = 2,
  localparam int BANK_SEL_W = $clog2(NUM_BANKS)
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              REQ,
  input  logic                              R_W,
  input  logic [BANK_SEL_W+BANK_ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0]                 DATA_IN,
  output logic                              READY,
  output logic [DATA_W-1:0]                 DATA_OUT,
  output logic                              DOUT_VALID
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [BANK_ADDR_W-1:0] LAST_WORD = {BANK_ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{1'b0}};

  logic [0:0]             state_r;
  logic [BANK_ADDR_W-1:0] cnt_r;
  logic                   ready_r;
  logic                   valid_r;
  logic [BANK_SEL_W-1:0]  sel_r;

  logic [BANK_SEL_W-1:0]  bank_s;
  logic [BANK_ADDR_W-1:0] word_s;
  logic                   init_s;
  logic                   wr_s;
  logic                   rd_s;
  logic [DATA_W-1:0]      bank_q_s [NUM_BANKS];

  // Address split and access qualification; requests only count in RUN.
  always_comb begin
    bank_s = ADDR[BANK_SEL_W+BANK_ADDR_W-1 -: BANK_SEL_W];
    word_s = ADDR[BANK_ADDR_W-1:0];
    init_s = (state_r == ST_INIT);
    wr_s   = (state_r == ST_RUN) && REQ && !R_W;
    rd_s   = (state_r == ST_RUN) && REQ && R_W;
  end

  // Control: zero-fill sweep, READY, read strobe and registered bank select.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_INIT;
      cnt_r   <= {BANK_ADDR_W{1'b0}};
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      sel_r   <= {BANK_SEL_W{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r   <= cnt_r + BANK_ADDR_W'(1);
          valid_r <= 1'b0;
          if (cnt_r == LAST_WORD) begin
            // Last index written this edge; cnt_r wraps back to 0.
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end else begin
            state_r <= ST_INIT;
            ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          ready_r <= 1'b1;
          valid_r <= rd_s;
          if (rd_s) begin
            sel_r <= bank_s;
          end
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= {BANK_ADDR_W{1'b0}};
          ready_r <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem_r [2**BANK_ADDR_W];
    logic [DATA_W-1:0] q_r;
    logic              hit_s;

    assign hit_s = (bank_s == BANK_SEL_W'(b));

    // Storage: zero-fill during INIT, addressed write in RUN; untouched in reset.
    always_ff @(posedge CLK) begin
      if (RST_N) begin
        if (init_s) begin
          mem_r[cnt_r] <= ZERO_WORD;
        end else if (wr_s && hit_s) begin
          mem_r[word_s] <= DATA_IN;
        end
      end
    end

    // Per-bank read register: only the addressed bank samples its array.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        q_r <= ZERO_WORD;
      end else if (rd_s && hit_s) begin
        q_r <= mem_r[word_s];
      end
    end

    assign bank_q_s[b] = q_r;
  end

  // sel_r only moves on a read, so DATA_OUT holds between reads.
  assign DATA_OUT   = bank_q_s[sel_r];
  assign READY      = ready_r;
  assign DOUT_VALID = valid_r;

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Parametrised single-port synchronous RAM built from NUM_BANKS identical banks; the upper address bits select the bank and the lower bits the word.
- Successor to the fixed two-bank 8-bit memory, adding:
  - a request/ready handshake
  - a registered read with a valid strobe
  - an automatic zero-fill of the whole array after reset.
- Used as general data memory in the course datapath designs.

Parameters:
- DATA_W, 8, word width in bits.
- BANK_ADDR_W, 3, word-address bits per bank; each bank holds 2**BANK_ADDR_W words.
- NUM_BANKS, 2, number of banks; must be a power of two, at least 2.
- BANK_SEL_W, clog2(NUM_BANKS), derived, not overridden. Default value is 1.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST_N  in  1  reset; synchronous, active-low.
- REQ  in  1  access request, sampled on the rising edge.
- R_W  in  1  1 = read, 0 = write; qualified by REQ.
- ADDR  in  BANK_SEL_W+BANK_ADDR_W  address. ADDR[MSBs] selects the bank; ADDR[BANK_ADDR_W-1:0] selects the word.
- DATA_IN  in  DATA_W  write data.
- READY  out  1  high when a request is accepted this cycle.
- DATA_OUT  out  DATA_W  registered read data.
- DOUT_VALID  out  1  one-cycle strobe; DATA_OUT holds new read data.

Behaviour:
- Reset:
  - RST_N low at a rising edge drives READY=0, DOUT_VALID=0, DATA_OUT=0, init counter=0, state=INIT.
  - Memory contents are not touched during reset itself.
- State INIT:
  - Each cycle, writes 0 to word index = counter in every bank in parallel, then increments counter.
  - When counter = 2**BANK_ADDR_W-1 is written, the next state is RUN.
  - Zero-fill takes exactly 2**BANK_ADDR_W cycles after RST_N rises. With defaults that is 8 cycles.
  - READY=0 for the whole of INIT. REQ is ignored and no DOUT_VALID is issued.
- State RUN:
  - READY=1 continuously; an access is accepted on any edge with REQ=1.
  - Write (REQ=1, R_W=0): DATA_IN is stored at the selected bank/word. Only the selected bank's write enable asserts. DOUT_VALID=0 next cycle and DATA_OUT is unchanged.
  - Read (REQ=1, R_W=1): the selected word is registered into DATA_OUT. DOUT_VALID=1 for exactly the following cycle, giving a latency of 1 cycle.
  - The bank-select bits are registered with the read and used by the output mux. Only the addressed bank is sampled.
  - REQ=0: DOUT_VALID=0 next cycle; DATA_OUT holds its last value.
  - Back-to-back reads produce DOUT_VALID high on consecutive cycles, each with its own data.
  - Write then read of the same address on the next cycle returns the new data. There is no write-through within a single cycle, since the block is single-port.
- Reset mid-operation:
  - RST_N low during RUN or INIT restarts INIT from counter 0.
  - Any read in flight is discarded: DOUT_VALID=0.
  - After the sweep, all locations read 0.
- Address range: every ADDR value is valid and there is no wrap or aliasing; each of NUM_BANKS*2**BANK_ADDR_W words is distinct.
- Storage: modelled as one array per bank, generated over NUM_BANKS. X-free after INIT.

Test Plan:
- Release RST_N, then hold REQ=1, R_W=1, ADDR=5 throughout INIT -> READY low for cycles 1-8 and no DOUT_VALID. In the cycle after READY rises, DOUT_VALID=1 and DATA_OUT=8'h00.
- Write 8'hA5 to ADDR=4'h3 and 8'h5A to ADDR=4'hB, then read 4'h3 and 4'hB back-to-back -> DOUT_VALID high on two consecutive cycles with 8'hA5 then 8'h5A. This proves the banks are independent.
- Write 8'h11 to ADDR=4'h2, then read ADDR=4'hA -> 8'h00, confirming no aliasing across banks.
- Write ADDR=7, then immediately read ADDR=7 on the next edge -> the new value appears with latency 1.
- Fill all 16 words with value=address, then pulse RST_N low for 1 cycle in the middle of a read burst -> the in-flight DOUT_VALID is suppressed, the 8-cycle INIT runs, and all 16 words read 0.
- Instance with DATA_W=16, BANK_ADDR_W=2, NUM_BANKS=4:
  - Write 16'hBEEF to ADDR=4'hD, then read it back -> 16'hBEEF.
  - INIT lasts 4 cycles.
